// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one dmem port between the CPU and the DMA/loader,
// with a tag pipeline that steers returning read data back to its owner.
module dmem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_q,
    input  logic              dma_req,
    input  logic              dma_wren,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_data,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_q,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    owner_t            last_owner;
    logic              any_gnt;
    logic              gnt_wren;
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_owner;

    // On conflict the side that did not win last time gets the port; reset blocks all grants.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && (!dma_req || last_owner == OWNER_DMA)) begin
                cpu_gnt = 1'b1;
            end else if (dma_req) begin
                dma_gnt = 1'b1;
            end
        end
    end

    assign any_gnt     = cpu_gnt | dma_gnt;
    assign gnt_wren    = dma_gnt ? dma_wren : cpu_wren;
    assign mem_address = dma_gnt ? dma_addr : cpu_addr;
    assign mem_data    = dma_gnt ? dma_data : cpu_data;
    assign mem_wren    = any_gnt & gnt_wren;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner <= OWNER_DMA;
            pipe_valid <= '0;
            pipe_owner <= '0;
        end else begin
            if (any_gnt) begin
                last_owner <= dma_gnt ? OWNER_DMA : OWNER_CPU;
            end
            pipe_valid[0] <= any_gnt & ~gnt_wren;
            pipe_owner[0] <= dma_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    // Reads still in flight when reset rises must never surface as rvalid.
    assign cpu_rvalid = ~reset & pipe_valid[RD_LAT-1] & ~pipe_owner[RD_LAT-1];
    assign dma_rvalid = ~reset & pipe_valid[RD_LAT-1] &  pipe_owner[RD_LAT-1];
    assign cpu_q      = mem_q;
    assign dma_q      = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter driving a small synchronous RAM model with
// one cycle of read latency.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    logic              clock;
    logic              reset;
    logic              cpu_req, cpu_wren, cpu_gnt, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data, cpu_q;
    logic              dma_req, dma_wren, dma_gnt, dma_rvalid;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_data, dma_q;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data, mem_q;
    logic              mem_wren;
    logic              preload;
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_q(cpu_q),
        .dma_req(dma_req), .dma_wren(dma_wren), .dma_addr(dma_addr), .dma_data(dma_data),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_q(dma_q),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (preload) begin
            ram[12'h010] <= 32'hDEADBEEF;
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        mem_q <= ram[mem_address];
    end

    task automatic apply_stimulus(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                                  input logic [DATA_W-1:0] cd, input logic dr, input logic dw,
                                  input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
        cpu_req = cr; cpu_wren = cw; cpu_addr = ca; cpu_data = cd;
        dma_req = dr; dma_wren = dw; dma_addr = da; dma_data = dd;
    endtask

    task automatic check_output(input string tag, input logic [DATA_W-1:0] observed,
                                input logic [DATA_W-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        reset   = 1'b1;
        preload = 1'b1;
        idle();
        tick();
        preload = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h055, 32'h0);
        @(negedge clock);
        check_output("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
        check_output("rst_dma_gnt", {31'b0, dma_gnt}, 32'd0);
        check_output("rst_wren", {31'b0, mem_wren}, 32'd0);
        check_output("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        check_output("rst_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
        tick();

        // CPU read of the preloaded word
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        check_output("rd_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        check_output("rd_mem_addr", {20'b0, mem_address}, 32'h010);
        check_output("rd_wren", {31'b0, mem_wren}, 32'd0);
        tick();
        idle();
        @(negedge clock);
        check_output("rd_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        check_output("rd_cpu_q", cpu_q, 32'hDEADBEEF);
        check_output("rd_dma_rvalid", {31'b0, dma_rvalid}, 32'd0);
        tick();

        // Fresh reset, then both write in the first cycle: CPU must win
        reset = 1'b1;
        tick();
        reset = 1'b0;
        apply_stimulus(1'b1, 1'b1, 12'h020, 32'h11, 1'b1, 1'b1, 12'h021, 32'h22);
        @(negedge clock);
        check_output("cw_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        check_output("cw_dma_gnt", {31'b0, dma_gnt}, 32'd0);
        check_output("cw_mem_data", mem_data, 32'h11);
        check_output("cw_wren", {31'b0, mem_wren}, 32'd1);
        tick();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h021, 32'h22);
        @(negedge clock);
        check_output("dw_dma_gnt", {31'b0, dma_gnt}, 32'd1);
        check_output("dw_mem_addr", {20'b0, mem_address}, 32'h021);
        check_output("dw_mem_data", mem_data, 32'h22);
        tick();
        apply_stimulus(1'b1, 1'b0, 12'h020, '0, 1'b0, 1'b0, '0, '0);
        tick();
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h021, '0);
        @(negedge clock);
        check_output("rb_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        check_output("rb_cpu_q", cpu_q, 32'h11);
        check_output("rb_dma_gnt", {31'b0, dma_gnt}, 32'd1);
        tick();
        idle();
        @(negedge clock);
        check_output("rb_dma_rvalid", {31'b0, dma_rvalid}, 32'd1);
        check_output("rb_dma_q", dma_q, 32'h22);
        tick();

        // Continuous conflicting reads: last owner is DMA, so C,D,C,D,C,D
        apply_stimulus(1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h020, '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check_output($sformatf("alt_cpu_gnt%0d", k), {31'b0, cpu_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_output($sformatf("alt_dma_gnt%0d", k), {31'b0, dma_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) begin
                check_output($sformatf("alt_cpu_rv%0d", k), {31'b0, cpu_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
                check_output($sformatf("alt_dma_rv%0d", k), {31'b0, dma_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
                check_output($sformatf("alt_q%0d", k), cpu_q, (k % 2 == 1) ? 32'hDEADBEEF : 32'h11);
            end
            tick();
        end
        idle();
        @(negedge clock);
        check_output("alt_last_dma_rv", {31'b0, dma_rvalid}, 32'd1);
        check_output("alt_last_cpu_rv", {31'b0, cpu_rvalid}, 32'd0);
        check_output("alt_last_q", dma_q, 32'h11);
        tick();
        @(negedge clock);
        check_output("alt_drain_rv", {31'b0, cpu_rvalid | dma_rvalid}, 32'd0);

        // DMA write then CPU read of the same word
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h030, 32'h55);
        @(negedge clock);
        check_output("dwr_dma_gnt", {31'b0, dma_gnt}, 32'd1);
        check_output("dwr_wren", {31'b0, mem_wren}, 32'd1);
        tick();
        apply_stimulus(1'b1, 1'b0, 12'h030, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        check_output("dwr_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        check_output("dwr_wren_off", {31'b0, mem_wren}, 32'd0);
        tick();
        idle();
        @(negedge clock);
        check_output("dwr_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        check_output("dwr_cpu_q", cpu_q, 32'h55);
        check_output("dwr_wren_idle", {31'b0, mem_wren}, 32'd0);
        tick();

        // CPU read dropped by reset; a DMA write during reset must not land
        apply_stimulus(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clock);
        check_output("rr_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        tick();
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'h010, 32'h12345678);
        @(negedge clock);
        check_output("rr_cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
        check_output("rr_wren", {31'b0, mem_wren}, 32'd0);
        check_output("rr_dma_gnt", {31'b0, dma_gnt}, 32'd0);
        tick();
        @(negedge clock);
        check_output("rr_wren2", {31'b0, mem_wren}, 32'd0);
        tick();
        reset = 1'b0;
        idle();
        @(negedge clock);
        check_output("rr_post_rvalid", {31'b0, cpu_rvalid | dma_rvalid}, 32'd0);
        apply_stimulus(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
        tick();
        idle();
        @(negedge clock);
        check_output("rr_ram_kept", cpu_q, 32'hDEADBEEF);
        tick();

        // Last owner is CPU: conflict goes to DMA, an idle gap, then CPU wins
        apply_stimulus(1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h020, '0);
        @(negedge clock);
        check_output("gap1_dma_gnt", {31'b0, dma_gnt}, 32'd1);
        check_output("gap1_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_output($sformatf("gap_idle_gnt%0d", k), {30'b0, cpu_gnt, dma_gnt}, 32'd0);
            check_output($sformatf("gap_idle_wren%0d", k), {31'b0, mem_wren}, 32'd0);
            tick();
        end
        apply_stimulus(1'b1, 1'b0, 12'h010, '0, 1'b1, 1'b0, 12'h020, '0);
        @(negedge clock);
        check_output("gap2_cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        check_output("gap2_dma_gnt", {31'b0, dma_gnt}, 32'd0);
        tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single dmem port between two requesters: the processor (CPU port) and a DMA/loader engine (DMA port).
- Sits between the requesters and the dmem syncram instance. Drives the dmem address, data and wren signals.
- Round-robin on conflict.
- Tags each granted read and routes the returned q to the owner after a fixed read latency.

Parameters:
ADDR_W, 12, dmem address width
DATA_W, 32, dmem data width
RD_LAT, 1, cycles from granted read to valid mem_q (>=1)

Ports:
clock  in  1  single block clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request, held until granted
cpu_wren  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_data  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_q  out  DATA_W  CPU read data
dma_req  in  1  DMA access request
dma_wren  in  1  DMA write enable
dma_addr  in  ADDR_W  DMA address
dma_data  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access accepted this cycle
dma_rvalid  out  1  DMA read data valid
dma_q  out  DATA_W  DMA read data
mem_address  out  ADDR_W  to dmem address
mem_data  out  DATA_W  to dmem data
mem_wren  out  1  to dmem wren
mem_q  in  DATA_W  from dmem q

Behaviour:
- Clock and reset: one clock domain on clock; reset is synchronous, active-high.
- Grant is combinational from the requests plus the registered pointer last_owner (0 = CPU, 1 = DMA).
- At most one grant per cycle.
- Arbitration:
  - Only cpu_req: cpu_gnt = 1.
  - Only dma_req: dma_gnt = 1.
  - Both: grant goes to the requester that is not last_owner.
  - Neither: no grant.
- last_owner update: on each grant, last_owner <= the granted requester at the clock edge. It holds when there is no grant.
- Muxing:
  - mem_address and mem_data follow the granted requester's addr and data.
  - mem_wren = granted requester's wren AND gnt.
  - With no grant, mem_wren = 0 and mem_address/mem_data hold the CPU values; only the no-write behaviour is required here.
- Handshake:
  - An access completes in the cycle its gnt is 1.
  - A requester that is not granted keeps req, addr, data and wren stable until granted. The arbiter does not latch them.
  - Writes need no response.
- Read tracking: a shift pipeline of RD_LAT stages, each stage holding {valid, owner}.
  - Stage 0 is loaded with valid = (grant AND NOT wren) and owner = the granted requester.
  - Stage RD_LAT-1 drives the outputs:
    - cpu_rvalid = valid AND owner == CPU.
    - dma_rvalid = valid AND owner == DMA.
  - cpu_q and dma_q both equal mem_q (unqualified). Consumers qualify with rvalid.
- Throughput: back-to-back grants are allowed every cycle, including alternating owners.
  - Reads are pipelined, so up to RD_LAT reads can be in flight.
- Starvation bound: with both requesting continuously, grants alternate strictly. A waiting requester is granted within 1 cycle.
- Reset:
  - While reset = 1: cpu_gnt = dma_gnt = 0, mem_wren = 0, cpu_rvalid = dma_rvalid = 0.
  - At the edge: last_owner <= DMA, so the CPU wins the first conflict, and all pipeline valid bits are cleared.
  - Reset mid-read: in-flight reads are dropped and produce no rvalid.
  - Reset mid-write: the write is not issued in any cycle where reset = 1.
- Simultaneous events:
  - A new grant and a pipeline output in the same cycle are independent.
  - A write by one requester and rvalid of the other's earlier read in the same cycle are both legal.
- Address range: no decoding; the full 2^ADDR_W range is passed through.

Test Plan:
- Reset release, then CPU read of addr 0x010 (dmem preloaded 0x010 = 0xDEADBEEF) -> cpu_gnt = 1 the same cycle; cpu_rvalid = 1 with cpu_q = 0xDEADBEEF exactly RD_LAT cycles later; dma_rvalid stays 0.
- Both request in the first cycle after reset (CPU write 0x020 <- 0x11, DMA write 0x021 <- 0x22) -> cycle 0 CPU granted, cycle 1 DMA granted; readback gives 0x11 and 0x22.
- Both continuously request reads for 6 cycles -> grants alternate C, D, C, D, C, D; each rvalid owner tag matches its grant RD_LAT cycles later; no missing or duplicate rvalid.
- DMA writes 0x030 <- 0x55 while the CPU is idle, then the CPU reads 0x030 on the next cycle -> cpu_q = 0x55; mem_wren is high for exactly 1 cycle.
- CPU read granted, then reset asserted in the next cycle -> no cpu_rvalid; while reset = 1, mem_wren = 0 even with dma_req = 1 and dma_wren = 1; dmem contents unchanged.
- Neither requests -> mem_wren = 0, both gnt = 0, last_owner unchanged (checked by a subsequent conflict resolving to the same side as before the idle gap).
